vdp_cpu_interface: RTL and testbench
====================================

Name: vdp_cpu_interface

Overview:
- CPU-side port of the VDP: the write/command end of the VRAM/CRAM/register storage that the display interface reads.
- Decodes Z80 accesses to the VDP data port and control port (two-byte command protocol, code/address registers, read-ahead buffer).
- Drives VRAM writes and prefetch reads, CRAM writes, and VDP register writes.
- Sits between the Z80 bus glue and the VRAM/CRAM mem instances and the VDP register file.

Parameters:
- VRAM_AW, 14, VRAM address width.
- CRAM_AW, 5, CRAM address width.
- CRAM_DW, 6, CRAM data width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cpu_port_sel  input  1  0 = data port, 1 = control port.
- cpu_wr  input  1  one-cycle write strobe.
- cpu_rd  input  1  one-cycle read strobe.
- cpu_data_in  input  8  CPU write data.
- cpu_data_out  output  8  CPU read data, valid the cycle after cpu_rd.
- cpu_ready  output  1  high when a new strobe is accepted.
- status_in  input  8  VDP status byte, returned on control-port read.
- status_rd  output  1  one-cycle pulse on control-port read (status flag clear).
- vram_addr  output  VRAM_AW  VRAM address.
- vram_wdata  output  8  VRAM write data.
- vram_we  output  1  VRAM write enable.
- vram_re  output  1  VRAM read enable.
- vram_rdata  input  8  VRAM read data, one-cycle latency after vram_re.
- cram_addr  output  CRAM_AW  CRAM address.
- cram_wdata  output  CRAM_DW  CRAM write data.
- cram_we  output  1  CRAM write enable.
- reg_wr  output  1  register write pulse.
- reg_addr  output  4  register index.
- reg_data  output  8  register value.

Behaviour:
- State: addr_reg[13:0], code_reg[1:0], first_byte flag (1 = expecting first control byte), latch_lo[7:0], read_buf[7:0], FSM {IDLE, FETCH, CAPTURE}.
- Reset:
  - addr_reg = 0, code_reg = 0, first_byte = 1, latch_lo = 0, read_buf = 0, FSM = IDLE.
  - All enables/pulses 0, cpu_data_out = 0, cpu_ready = 1.
- cpu_ready = 1 only in IDLE. Strobes while cpu_ready = 0 are ignored with no state change.
- cpu_wr and cpu_rd asserted together: the read is ignored, the write is performed.
- Control write, first_byte = 1: latch_lo <= data, addr_reg[7:0] <= data, first_byte <= 0.
- Control write, first_byte = 0: code_reg <= data[7:6], addr_reg <= {data[5:0], latch_lo}, first_byte <= 1. Then by code:
  - Code 0: start prefetch (IDLE -> FETCH).
  - Code 1 or 3: no memory access.
  - Code 2: reg_wr = 1 for one cycle (next cycle), reg_addr = data[3:0], reg_data = latch_lo. Code register is still updated.
- Control read: cpu_data_out <= status_in next cycle, status_rd pulses for one cycle, first_byte <= 1.
- Data write (any code): first_byte <= 1, read_buf <= data, addr_reg <= addr_reg + 1.
  - code_reg == 3: cram_we = 1 for one cycle, cram_addr = addr_reg[4:0], cram_wdata = data[5:0].
  - Otherwise: vram_we = 1 for one cycle, vram_addr = addr_reg (pre-increment), vram_wdata = data.
- Data read: cpu_data_out <= read_buf next cycle, first_byte <= 1, start prefetch.
- Prefetch FSM:
  - FETCH (one cycle): vram_re = 1, vram_addr = addr_reg; addr_reg increments.
  - CAPTURE (one cycle): read_buf <= vram_rdata.
  - Then IDLE.
  - cpu_ready is low for exactly 2 cycles after the triggering access.
- Address increment wraps 14'h3FFF -> 14'h0000. CRAM uses the low 5 bits only, so the CRAM address wraps at 31 -> 0.
- All memory and register outputs are registered; each enable is high for exactly one cycle per access.
- Reset asserted mid-prefetch aborts the FSM to IDLE, and read_buf = 0.

Test Plan:
- Reset, then control writes 0x34, 0x52 (code 1, addr 0x1234); data writes 0xAA, 0xBB -> vram_we pulses at addr 0x1234 data 0xAA, then 0x1235 data 0xBB; addr_reg = 0x1236.
- Preload VRAM[0x0100] = 0x5C, VRAM[0x0101] = 0x7E; control 0x00, 0x01 (code 0) -> vram_re at 0x0100, cpu_ready low 2 cycles; data read returns 0x5C; next data read returns 0x7E.
- Control writes 0x86, 0x81 -> reg_wr one cycle with reg_addr 1, reg_data 0x86; no VRAM/CRAM access.
- Control 0x1F, 0xC0 (code 3, addr 31); data writes 0x3F, 0x15 -> cram_we at addr 31 data 0x3F, then addr 0 data 0x15.
- Control write 0x12, then control read (status_in = 0x80) -> cpu_data_out 0x80, status_rd pulses; control writes 0x00, 0x40 -> addr_reg = 0x0000, code 1 (first byte not merged).
- Address 0x3FFF with code 1, data write -> vram_addr 0x3FFF, then addr_reg 0x0000. Reset during FETCH -> FSM IDLE, cpu_ready = 1, read_buf = 0.

Source files
------------

// File: rtl/vdp_cpu_interface.sv
// vdp_cpu_interface: Z80 data/control port decoder driving VRAM, CRAM and VDP register writes
// plus the VRAM read-ahead buffer.
module vdp_cpu_interface #(
    parameter int VRAM_AW = 14,
    parameter int CRAM_AW = 5,
    parameter int CRAM_DW = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_port_sel,
    input  logic               cpu_wr,
    input  logic               cpu_rd,
    input  logic [7:0]         cpu_data_in,
    output logic [7:0]         cpu_data_out,
    output logic               cpu_ready,
    input  logic [7:0]         status_in,
    output logic               status_rd,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    output logic               vram_we,
    output logic               vram_re,
    input  logic [7:0]         vram_rdata,
    output logic [CRAM_AW-1:0] cram_addr,
    output logic [CRAM_DW-1:0] cram_wdata,
    output logic               cram_we,
    output logic               reg_wr,
    output logic [3:0]         reg_addr,
    output logic [7:0]         reg_data
);
    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE} state_t;
    state_t      state;
    logic [13:0] addr_reg;
    logic [1:0]  code_reg;
    logic        first_byte;
    logic [7:0]  latch_lo;
    logic [7:0]  read_buf;
    logic [13:0] ctl_addr;
    logic        wr_ok;
    logic        rd_ok;
    assign cpu_ready = state == IDLE;
    assign wr_ok     = cpu_wr && cpu_ready;
    // a simultaneous read is dropped in favour of the write
    assign rd_ok     = cpu_rd && !cpu_wr && cpu_ready;
    assign ctl_addr  = {cpu_data_in[5:0], latch_lo};
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_reg     <= '0;
            code_reg     <= '0;
            first_byte   <= 1'b1;
            latch_lo     <= '0;
            read_buf     <= '0;
            cpu_data_out <= '0;
            status_rd    <= 1'b0;
            vram_addr    <= '0;
            vram_wdata   <= '0;
            vram_we      <= 1'b0;
            vram_re      <= 1'b0;
            cram_addr    <= '0;
            cram_wdata   <= '0;
            cram_we      <= 1'b0;
            reg_wr       <= 1'b0;
            reg_addr     <= '0;
            reg_data     <= '0;
        end else begin
            vram_we   <= 1'b0;
            vram_re   <= 1'b0;
            cram_we   <= 1'b0;
            reg_wr    <= 1'b0;
            status_rd <= 1'b0;
            case (state)
                FETCH: begin
                    addr_reg <= addr_reg + 14'd1;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    read_buf <= vram_rdata;
                    state    <= IDLE;
                end
                default: begin
                    if (wr_ok && cpu_port_sel) begin
                        if (first_byte) begin
                            latch_lo       <= cpu_data_in;
                            addr_reg[7:0]  <= cpu_data_in;
                            first_byte     <= 1'b0;
                        end else begin
                            code_reg   <= cpu_data_in[7:6];
                            addr_reg   <= ctl_addr;
                            first_byte <= 1'b1;
                            if (cpu_data_in[7:6] == 2'd0) begin
                                state     <= FETCH;
                                vram_re   <= 1'b1;
                                vram_addr <= ctl_addr[VRAM_AW-1:0];
                            end
                            if (cpu_data_in[7:6] == 2'd2) begin
                                reg_wr   <= 1'b1;
                                reg_addr <= cpu_data_in[3:0];
                                reg_data <= latch_lo;
                            end
                        end
                    end else if (wr_ok) begin
                        first_byte <= 1'b1;
                        read_buf   <= cpu_data_in;
                        addr_reg   <= addr_reg + 14'd1;
                        if (code_reg == 2'd3) begin
                            cram_we    <= 1'b1;
                            cram_addr  <= addr_reg[CRAM_AW-1:0];
                            cram_wdata <= cpu_data_in[CRAM_DW-1:0];
                        end else begin
                            vram_we    <= 1'b1;
                            vram_addr  <= addr_reg[VRAM_AW-1:0];
                            vram_wdata <= cpu_data_in;
                        end
                    end else if (rd_ok && cpu_port_sel) begin
                        cpu_data_out <= status_in;
                        status_rd    <= 1'b1;
                        first_byte   <= 1'b1;
                    end else if (rd_ok) begin
                        cpu_data_out <= read_buf;
                        first_byte   <= 1'b1;
                        state        <= FETCH;
                        vram_re      <= 1'b1;
                        vram_addr    <= addr_reg[VRAM_AW-1:0];
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vdp_cpu_interface.sv
// tb_vdp_cpu_interface: directed vector table plus hand sequences for prefetch stall and reset abort.
module tb_vdp_cpu_interface;
    localparam logic [4:0] P_WE = 5'b10000, P_RE = 5'b01000, P_CR = 5'b00100,
                           P_RG = 5'b00010, P_ST = 5'b00001, P_NO = 5'b00000;
    typedef struct {
        logic       sel;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [7:0] status;
        logic [4:0] pulses;
        logic [13:0] addr;
        logic [7:0] data;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_port_sel = 1'b0, cpu_wr = 1'b0, cpu_rd = 1'b0;
    logic [7:0]  cpu_data_in = '0, status_in = '0;
    logic [7:0]  cpu_data_out, vram_wdata, reg_data;
    logic [7:0]  vram_rdata = '0;
    logic        cpu_ready, status_rd, vram_we, vram_re, cram_we, reg_wr;
    logic [13:0] vram_addr;
    logic [4:0]  cram_addr;
    logic [5:0]  cram_wdata;
    logic [3:0]  reg_addr;
    logic [7:0]  mem [0:16383];
    int unsigned n_pass = 0, n_total = 0;
    vec_t        vq[$];
    vdp_cpu_interface dut (
        .clk(clk), .rst(rst), .cpu_port_sel(cpu_port_sel), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready),
        .status_in(status_in), .status_rd(status_rd), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_re(vram_re), .vram_rdata(vram_rdata),
        .cram_addr(cram_addr), .cram_wdata(cram_wdata), .cram_we(cram_we),
        .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data)
    );
    always #5 clk = ~clk;
    // VRAM model: preloaded during reset, one-cycle read latency
    always @(posedge clk) begin
        if (rst) begin
            mem[14'h0100] <= 8'h5C;
            mem[14'h0101] <= 8'h7E;
        end else if (vram_we) begin
            mem[vram_addr] <= vram_wdata;
        end
        if (vram_re) vram_rdata <= mem[vram_addr];
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic strobe(input logic sel, input logic wr, input logic rd, input logic [7:0] din);
        @(negedge clk);
        cpu_port_sel = sel;
        cpu_wr = wr;
        cpu_rd = rd;
        cpu_data_in = din;
        @(posedge clk);
        #1;
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
    endtask
    function automatic vec_t mk(logic sel, logic wr, logic rd, logic [7:0] din, logic [7:0] st,
                                logic [4:0] p, logic [13:0] a, logic [7:0] d);
        vec_t v;
        v.sel = sel; v.wr = wr; v.rd = rd; v.din = din; v.status = st;
        v.pulses = p; v.addr = a; v.data = d;
        return v;
    endfunction
    initial begin
        vq.push_back(mk(1, 1, 0, 8'h34, 0, P_NO, 14'h0000, 8'h00));
        vq.push_back(mk(1, 1, 0, 8'h52, 0, P_NO, 14'h0000, 8'h00));
        vq.push_back(mk(0, 1, 0, 8'hAA, 0, P_WE, 14'h1234, 8'hAA));
        vq.push_back(mk(0, 1, 0, 8'hBB, 0, P_WE, 14'h1235, 8'hBB));
        vq.push_back(mk(0, 0, 1, 8'h00, 0, P_RE, 14'h1236, 8'hBB));
        vq.push_back(mk(1, 1, 0, 8'h00, 0, P_NO, 14'h0000, 8'h00));
        vq.push_back(mk(1, 1, 0, 8'h01, 0, P_RE, 14'h0100, 8'h00));
        vq.push_back(mk(0, 0, 1, 8'h00, 0, P_RE, 14'h0101, 8'h5C));
        vq.push_back(mk(0, 0, 1, 8'h00, 0, P_RE, 14'h0102, 8'h7E));
        vq.push_back(mk(1, 1, 0, 8'h86, 0, P_NO, 14'h0000, 8'h00));
        vq.push_back(mk(1, 1, 0, 8'h81, 0, P_RG, 14'h0001, 8'h86));
        vq.push_back(mk(1, 1, 0, 8'h1F, 0, P_NO, 14'h0000, 8'h00));
        vq.push_back(mk(1, 1, 0, 8'hC0, 0, P_NO, 14'h0000, 8'h00));
        vq.push_back(mk(0, 1, 0, 8'h3F, 0, P_CR, 14'h001F, 8'h3F));
        vq.push_back(mk(0, 1, 0, 8'h15, 0, P_CR, 14'h0000, 8'h15));
        vq.push_back(mk(1, 1, 0, 8'h12, 0, P_NO, 14'h0000, 8'h00));
        vq.push_back(mk(1, 0, 1, 8'h00, 8'h80, P_ST, 14'h0000, 8'h80));
        vq.push_back(mk(1, 1, 0, 8'h00, 0, P_NO, 14'h0000, 8'h00));
        vq.push_back(mk(1, 1, 0, 8'h40, 0, P_NO, 14'h0000, 8'h00));
        vq.push_back(mk(0, 1, 0, 8'h99, 0, P_WE, 14'h0000, 8'h99));
        vq.push_back(mk(1, 1, 0, 8'hFF, 0, P_NO, 14'h0000, 8'h00));
        vq.push_back(mk(1, 1, 0, 8'h7F, 0, P_NO, 14'h0000, 8'h00));
        vq.push_back(mk(0, 1, 0, 8'h11, 0, P_WE, 14'h3FFF, 8'h11));
        vq.push_back(mk(0, 1, 0, 8'h22, 0, P_WE, 14'h0000, 8'h22));
        vq.push_back(mk(0, 1, 1, 8'h33, 0, P_WE, 14'h0001, 8'h33));
        vq.push_back(mk(1, 1, 0, 8'h00, 0, P_NO, 14'h0000, 8'h00));
        vq.push_back(mk(1, 1, 0, 8'h00, 0, P_RE, 14'h0000, 8'h00));
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", cpu_ready, 1);
        chk("reset_dout", cpu_data_out, 0);
        chk("reset_pulses", {vram_we, vram_re, cram_we, reg_wr, status_rd}, 0);
        chk("reset_vaddr", vram_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            status_in = vq[i].status;
            strobe(vq[i].sel, vq[i].wr, vq[i].rd, vq[i].din);
            chk($sformatf("v%0d_pulses", i), {vram_we, vram_re, cram_we, reg_wr, status_rd},
                vq[i].pulses);
            if (vq[i].pulses[4] || vq[i].pulses[3])
                chk($sformatf("v%0d_vaddr", i), vram_addr, vq[i].addr);
            if (vq[i].pulses[4]) chk($sformatf("v%0d_vwdata", i), vram_wdata, vq[i].data);
            if (vq[i].pulses[2]) begin
                chk($sformatf("v%0d_caddr", i), cram_addr, vq[i].addr[4:0]);
                chk($sformatf("v%0d_cwdata", i), cram_wdata, vq[i].data[5:0]);
            end
            if (vq[i].pulses[1]) begin
                chk($sformatf("v%0d_raddr", i), reg_addr, vq[i].addr[3:0]);
                chk($sformatf("v%0d_rdata", i), reg_data, vq[i].data);
            end
            if (vq[i].rd && !vq[i].wr) chk($sformatf("v%0d_dout", i), cpu_data_out, vq[i].data);
            if (vq[i].pulses[3]) begin
                chk($sformatf("v%0d_busy1", i), cpu_ready, 0);
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_busy2", i), cpu_ready, 0);
                @(posedge clk);
                #1;
            end
            chk($sformatf("v%0d_ready", i), cpu_ready, 1);
        end
        // the last vector left a prefetch of address 0; strobe while it is busy
        strobe(1, 1, 0, 8'h00);
        strobe(1, 1, 0, 8'h00);
        chk("busy_state", cpu_ready, 0);
        strobe(0, 1, 0, 8'hEE);
        chk("busy_wr_ignored", vram_we, 0);
        chk("busy_capture", cpu_ready, 0);
        @(posedge clk);
        #1;
        strobe(0, 0, 1, 8'h00);
        chk("busy_readbuf", cpu_data_out, 8'h22);
        chk("busy_next_addr", vram_addr, 14'h0001);
        repeat (2) @(posedge clk);
        #1;
        strobe(0, 0, 1, 8'h00);
        chk("busy_read2", cpu_data_out, 8'h33);
        repeat (2) @(posedge clk);
        #1;
        strobe(0, 1, 0, 8'h5A);
        // reset lands in FETCH and must wipe read_buf
        strobe(1, 1, 0, 8'h00);
        strobe(1, 1, 0, 8'h01);
        chk("abort_in_fetch", vram_re, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", cpu_ready, 1);
        chk("abort_re", vram_re, 0);
        @(negedge clk);
        rst = 1'b0;
        strobe(0, 0, 1, 8'h00);
        chk("abort_readbuf", cpu_data_out, 8'h00);
        chk("abort_addr", vram_addr, 14'h0000);
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
